// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4:1 TDM link; rebuilds four channel words per frame.
// Optional resync-error pulse output frame_err is enabled with `define TDM_DEMUX4_ERR_EN.
module tdm_demux4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic             frame_valid,
   output logic [1:0]       slot,
   output logic             locked
`ifdef TDM_DEMUX4_ERR_EN
  ,output logic             frame_err
`endif
);

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [1:0]       r_slot;
   logic             r_locked;
   logic             r_frame_valid;
   logic             r_frame_err;
   logic [WIDTH-1:0] r_shadow0;
   logic [WIDTH-1:0] r_shadow1;
   logic [WIDTH-1:0] r_shadow2;
   logic [WIDTH-1:0] r_out0;
   logic [WIDTH-1:0] r_out1;
   logic [WIDTH-1:0] r_out2;
   logic [WIDTH-1:0] r_out3;

   // A sync beat arriving anywhere but slot 0 while running drops the partial frame.
   logic w_resync;
   assign w_resync = in_valid && sync && (r_state == RUN) && (r_slot != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= HUNT;
         r_slot        <= 2'd0;
         r_locked      <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_shadow0     <= '0;
         r_shadow1     <= '0;
         r_shadow2     <= '0;
         r_out0        <= '0;
         r_out1        <= '0;
         r_out2        <= '0;
         r_out3        <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout; the pulse defaults below are
         // overridden later in the same block, and the last assignment wins.
         r_frame_valid <= 1'b0;
         r_frame_err   <= w_resync;
         if (in_valid) begin
            case (r_state)
               HUNT: begin
                  if (sync) begin
                     r_shadow0 <= in;
                     r_slot    <= 2'd1;
                     r_locked  <= 1'b1;
                     r_state   <= RUN;
                  end
               end
               RUN: begin
                  if (sync) begin
                     r_shadow0 <= in;
                     r_slot    <= 2'd1;
                  end else begin
                     case (r_slot)
                        2'd0: r_shadow0 <= in;
                        2'd1: r_shadow1 <= in;
                        2'd2: r_shadow2 <= in;
                        default: begin
                           r_out0        <= r_shadow0;
                           r_out1        <= r_shadow1;
                           r_out2        <= r_shadow2;
                           r_out3        <= in;
                           r_frame_valid <= 1'b1;
                        end
                     endcase
                     r_slot <= r_slot + 2'd1;
                  end
               end
               default: r_state <= HUNT;
            endcase
         end
      end
   end

   assign out0        = r_out0;
   assign out1        = r_out1;
   assign out2        = r_out2;
   assign out3        = r_out3;
   assign frame_valid = r_frame_valid;
   assign slot        = r_slot;
   assign locked      = r_locked;

`ifdef TDM_DEMUX4_ERR_EN
   assign frame_err = r_frame_err;
`else
   logic w_unused_err;
   assign w_unused_err = r_frame_err;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed self-checking bench for tdm_demux4 with a frame scoreboard.
// Covers the frame_err output too when built with `define TDM_DEMUX4_ERR_EN.
module tb_tdm_demux4;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] o0;
      logic [W-1:0] o1;
      logic [W-1:0] o2;
      logic [W-1:0] o3;
   } frame_t;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] in;
   logic         in_valid;
   logic         sync;
   logic [W-1:0] out0, out1, out2, out3;
   logic         frame_valid;
   logic [1:0]   slot;
   logic         locked;
`ifdef TDM_DEMUX4_ERR_EN
   logic         frame_err;
`endif

   int     n_checks = 0;
   int     n_fail   = 0;
   int     n_pulses = 0;
   frame_t exp_q[$];

   tdm_demux4 #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in          (in),
      .in_valid    (in_valid),
      .sync        (sync),
      .out0        (out0),
      .out1        (out1),
      .out2        (out2),
      .out3        (out3),
      .frame_valid (frame_valid),
      .slot        (slot),
      .locked      (locked)
`ifdef TDM_DEMUX4_ERR_EN
     ,.frame_err   (frame_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every frame_valid pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n && frame_valid === 1'b1) begin
         n_pulses++;
         if (exp_q.size() == 0) begin
            check("unexpected_frame_valid", 32'd1, 32'd0);
         end else begin
            frame_t e;
            e = exp_q.pop_front();
            check("out0", 32'(out0), 32'(e.o0));
            check("out1", 32'(out1), 32'(e.o1));
            check("out2", 32'(out2), 32'(e.o2));
            check("out3", 32'(out3), 32'(e.o3));
         end
      end
   end

   // One valid beat, launched 1 time unit after a rising edge and held for one cycle.
   task automatic beat(input logic [W-1:0] d, input logic s);
      in       = d;
      sync     = s;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      sync     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [W-1:0] a, b, c, d, input int stall);
      frame_t f;
      f = '{a, b, c, d};
      beat(a, 1'b1);
      idle(stall);
      beat(b, 1'b0);
      idle(stall);
      beat(c, 1'b0);
      idle(stall);
      exp_q.push_back(f);
      beat(d, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #13;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p0;
      rst_n    = 1'b0;
      in       = '0;
      in_valid = 1'b0;
      sync     = 1'b0;
      #2;
      check("rst_out0", 32'(out0), 32'd0);
      check("rst_out3", 32'(out3), 32'd0);
      check("rst_frame_valid", 32'(frame_valid), 32'd0);
      check("rst_slot", 32'(slot), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic frame on consecutive cycles.
      beat(4'b1100, 1'b1);
      check("t1_slot_after_sync", 32'(slot), 32'd1);
      check("t1_locked", 32'(locked), 32'd1);
      beat(4'b1101, 1'b0);
      beat(4'b1110, 1'b0);
      exp_q.push_back('{4'b1100, 4'b1101, 4'b1110, 4'b1111});
      p0 = n_pulses;
      beat(4'b1111, 1'b0);
      check("t1_frame_valid_hi", 32'(frame_valid), 32'd1);
      check("t1_slot_wrap", 32'(slot), 32'd0);
      idle(1);
      check("t1_frame_valid_lo", 32'(frame_valid), 32'd0);
      check("t1_out_hold", 32'(out2), 32'(4'b1110));
      check("t1_pulses", 32'(n_pulses - p0), 32'd1);

      // Hunt drops beats without sync.
      do_reset();
      beat(4'b0011, 1'b0);
      beat(4'b0101, 1'b0);
      check("t2_hunt_slot", 32'(slot), 32'd0);
      check("t2_hunt_locked", 32'(locked), 32'd0);
      p0 = n_pulses;
      send_frame(4'b1100, 4'b1101, 4'b1110, 4'b1111, 0);
      idle(2);
      check("t2_pulses", 32'(n_pulses - p0), 32'd1);

      // Stalls of three cycles between beats.
      p0 = n_pulses;
      beat(4'b1100, 1'b1);
      idle(3);
      check("t3_slot_hold1", 32'(slot), 32'd1);
      beat(4'b1101, 1'b0);
      idle(3);
      check("t3_slot_hold2", 32'(slot), 32'd2);
      beat(4'b1110, 1'b0);
      idle(3);
      check("t3_slot_hold3", 32'(slot), 32'd3);
      check("t3_no_early_pulse", 32'(n_pulses - p0), 32'd0);
      exp_q.push_back('{4'b1100, 4'b1101, 4'b1110, 4'b1111});
      beat(4'b1111, 1'b0);
      idle(2);
      check("t3_pulses", 32'(n_pulses - p0), 32'd1);

      // Resync mid-frame.
      p0 = n_pulses;
      beat(4'b1100, 1'b1);
      beat(4'b1101, 1'b0);
`ifdef TDM_DEMUX4_ERR_EN
      check("t4_err_before", 32'(frame_err), 32'd0);
`endif
      beat(4'b0001, 1'b1);
      check("t4_resync_slot", 32'(slot), 32'd1);
      check("t4_no_update", 32'(frame_valid), 32'd0);
`ifdef TDM_DEMUX4_ERR_EN
      check("t4_err_pulse", 32'(frame_err), 32'd1);
`endif
      beat(4'b0010, 1'b0);
`ifdef TDM_DEMUX4_ERR_EN
      check("t4_err_clear", 32'(frame_err), 32'd0);
`endif
      beat(4'b0011, 1'b0);
      exp_q.push_back('{4'b0001, 4'b0010, 4'b0011, 4'b0100});
      beat(4'b0100, 1'b0);
      idle(1);
      check("t4_pulses", 32'(n_pulses - p0), 32'd1);

      // Back-to-back frames, with a sync offered while in_valid is low.
      p0 = n_pulses;
      send_frame(4'b1100, 4'b1101, 4'b1110, 4'b1111, 0);
      beat(4'b0000, 1'b1);
      beat(4'b0001, 1'b0);
      sync = 1'b1;
      in   = 4'b1010;
      idle(1);
      sync = 1'b0;
      check("t5_gated_sync_slot", 32'(slot), 32'd2);
`ifdef TDM_DEMUX4_ERR_EN
      check("t5_gated_sync_err", 32'(frame_err), 32'd0);
`endif
      beat(4'b0010, 1'b0);
      exp_q.push_back('{4'b0000, 4'b0001, 4'b0010, 4'b0011});
      beat(4'b0011, 1'b0);
      idle(1);
      check("t5_pulses", 32'(n_pulses - p0), 32'd2);

      // Asynchronous reset mid-frame, between clock edges.
      beat(4'b0110, 1'b1);
      beat(4'b0111, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_out1", 32'(out1), 32'd0);
      check("t6_out3", 32'(out3), 32'd0);
      check("t6_slot", 32'(slot), 32'd0);
      check("t6_locked", 32'(locked), 32'd0);
      check("t6_frame_valid", 32'(frame_valid), 32'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      p0 = n_pulses;
      send_frame(4'b1001, 4'b1010, 4'b1011, 4'b0101, 0);
      idle(2);
      check("t6_pulses", 32'(n_pulses - p0), 32'd1);
      check("t6_out0", 32'(out0), 32'(4'b1001));

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
